// File: rtl/half_duplex_spi_pkg.sv
// Shared types and default sizing for the half-duplex SPI master.
package half_duplex_spi_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LEN_WIDTH  = 6;
    localparam int DEF_NUM_CS     = 4;
    localparam int DEF_DIV_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // A single chip select still needs a one-bit select port.
    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Half-period tick generator: ticks on the last cycle of every clk_div+1 cycle window.
module spi_halfperiod_timer
    import half_duplex_spi_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 fabric_clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;

    // Down-counter reloads from the latched divider, so all-ones never wraps.
    always_ff @(posedge fabric_clk or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            div_reg <= div;
            cnt_reg <= div;
        end else if (run) begin
            if (cnt_reg == '0) begin
                cnt_reg <= div_reg;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign tick = run && (cnt_reg == '0);

endmodule

// File: rtl/half_duplex_spi_master.sv
// Half-duplex 3-wire SPI master: per-bit direction mask, MSB-first, left-aligned data.
module half_duplex_spi_master
    import half_duplex_spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int NUM_CS     = DEF_NUM_CS,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                          fabric_clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LEN_WIDTH-1:0]          tx_len,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic [DATA_WIDTH-1:0]         tx_rw_mask,
    input  logic [cs_width(NUM_CS)-1:0]   cs_sel,
    input  logic [DIV_WIDTH-1:0]          clk_div,
    input  logic                          cpol,
    input  logic                          cpha,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          sclk,
    output logic [NUM_CS-1:0]             cs_n,
    output logic                          sdio_o,
    output logic                          sdio_oe,
    input  logic                          sdio_i
);

    localparam int CS_W = cs_width(NUM_CS);
    localparam logic [LEN_WIDTH:0]    MAX_LEN    = (LEN_WIDTH + 1)'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MSB_ONEHOT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    spi_state_t              state_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    error_reg;
    logic [DATA_WIDTH-1:0]   rx_data_reg;
    logic                    sclk_reg;
    logic [NUM_CS-1:0]       cs_n_reg;
    logic                    sdio_o_reg;
    logic                    sdio_oe_reg;

    logic [LEN_WIDTH-1:0]    len_reg;
    logic [DATA_WIDTH-1:0]   mask_reg;
    logic [DATA_WIDTH-1:0]   data_sh_reg;
    logic [DATA_WIDTH-1:0]   mask_sh_reg;
    logic [DATA_WIDTH-1:0]   rx_acc_reg;
    logic [DATA_WIDTH-1:0]   rx_ptr_reg;
    logic [LEN_WIDTH:0]      edge_cnt_reg;
    logic                    cpha_reg;

    logic [NUM_CS-1:0]       cs_onehot;
    logic                    len_bad;
    logic                    accept;
    logic                    hp_tick;
    logic [LEN_WIDTH:0]      len2;
    logic [LEN_WIDTH:0]      len2_m1;
    logic                    edge_now;
    logic                    edge_sample;
    logic                    edge_drive;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign cs_onehot[gi] = (cs_sel == CS_W'(gi));
        end
    endgenerate

    assign len_bad = (tx_len == '0) || ({1'b0, tx_len} > MAX_LEN);
    assign accept  = start && (state_reg == ST_IDLE) && !len_bad;

    spi_halfperiod_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .fabric_clk (fabric_clk),
        .reset      (reset),
        .load       (accept),
        .run        (state_reg != ST_IDLE),
        .div        (clk_div),
        .tick       (hp_tick)
    );

    // SCLK edge k opens SHIFT half-period k; even k is the leading edge of bit k/2.
    always_comb begin
        len2        = {len_reg, 1'b0};
        len2_m1     = len2 - 1'b1;
        edge_now    = hp_tick && ((state_reg == ST_SETUP) ||
                      ((state_reg == ST_SHIFT) && (edge_cnt_reg != len2)));
        edge_sample = edge_now && (edge_cnt_reg[0] == cpha_reg);
        edge_drive  = edge_now && (edge_cnt_reg[0] != cpha_reg) &&
                      (cpha_reg || (edge_cnt_reg != len2_m1));
    end

    always_ff @(posedge fabric_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            rx_data_reg  <= '0;
            sclk_reg     <= 1'b0;
            cs_n_reg     <= '1;
            sdio_o_reg   <= 1'b0;
            sdio_oe_reg  <= 1'b0;
            len_reg      <= '0;
            mask_reg     <= '0;
            data_sh_reg  <= '0;
            mask_sh_reg  <= '0;
            rx_acc_reg   <= '0;
            rx_ptr_reg   <= '0;
            edge_cnt_reg <= '0;
            cpha_reg     <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (len_bad) begin
                            error_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_SETUP;
                            busy_reg     <= 1'b1;
                            len_reg      <= tx_len;
                            mask_reg     <= tx_rw_mask;
                            cpha_reg     <= cpha;
                            sclk_reg     <= cpol;
                            cs_n_reg     <= ~cs_onehot;
                            edge_cnt_reg <= '0;
                            rx_acc_reg   <= '0;
                            rx_ptr_reg   <= MSB_ONEHOT;
                            // Mode cpha=0 must have bit 0 on the wire before the first edge.
                            if (!cpha) begin
                                sdio_oe_reg <= tx_rw_mask[DATA_WIDTH-1];
                                sdio_o_reg  <= tx_data[DATA_WIDTH-1] & tx_rw_mask[DATA_WIDTH-1];
                                data_sh_reg <= tx_data << 1;
                                mask_sh_reg <= tx_rw_mask << 1;
                            end else begin
                                sdio_oe_reg <= 1'b0;
                                sdio_o_reg  <= 1'b0;
                                data_sh_reg <= tx_data;
                                mask_sh_reg <= tx_rw_mask;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (hp_tick) begin
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (hp_tick && (edge_cnt_reg == len2)) begin
                        state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hp_tick) begin
                        state_reg   <= ST_GAP;
                        cs_n_reg    <= '1;
                        sdio_oe_reg <= 1'b0;
                        sdio_o_reg  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (hp_tick) begin
                        state_reg   <= ST_IDLE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_acc_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (edge_now) begin
                sclk_reg     <= ~sclk_reg;
                edge_cnt_reg <= edge_cnt_reg + 1'b1;
                // Only read positions may pick up the pad; write positions stay 0.
                if (edge_sample) begin
                    rx_acc_reg <= rx_acc_reg | (rx_ptr_reg & ~mask_reg & {DATA_WIDTH{sdio_i}});
                    rx_ptr_reg <= rx_ptr_reg >> 1;
                end
                if (edge_drive) begin
                    sdio_oe_reg <= mask_sh_reg[DATA_WIDTH-1];
                    sdio_o_reg  <= data_sh_reg[DATA_WIDTH-1] & mask_sh_reg[DATA_WIDTH-1];
                    data_sh_reg <= data_sh_reg << 1;
                    mask_sh_reg <= mask_sh_reg << 1;
                end
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign error   = error_reg;
    assign rx_data = rx_data_reg;
    assign sclk    = sclk_reg;
    assign cs_n    = cs_n_reg;
    assign sdio_o  = sdio_o_reg;
    assign sdio_oe = sdio_oe_reg;

endmodule

// File: tb/tb_half_duplex_spi_master.sv
// Randomised bench for half_duplex_spi_master against a bit-level transfer model.
module tb_half_duplex_spi_master;

    localparam int DW  = 32;
    localparam int LW  = 6;
    localparam int NCS = 4;
    localparam int DVW = 8;

    logic            fabric_clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   tx_len;
    logic [DW-1:0]   tx_data;
    logic [DW-1:0]   tx_rw_mask;
    logic [1:0]      cs_sel;
    logic [DVW-1:0]  clk_div;
    logic            cpol;
    logic            cpha;
    logic            busy;
    logic            done;
    logic            error;
    logic [DW-1:0]   rx_data;
    logic            sclk;
    logic [NCS-1:0]  cs_n;
    logic            sdio_o;
    logic            sdio_oe;
    logic            sdio_i = 1'b0;

    half_duplex_spi_master #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .NUM_CS     (NCS),
        .DIV_WIDTH  (DVW)
    ) dut (
        .fabric_clk (fabric_clk),
        .reset      (reset),
        .start      (start),
        .tx_len     (tx_len),
        .tx_data    (tx_data),
        .tx_rw_mask (tx_rw_mask),
        .cs_sel     (cs_sel),
        .clk_div    (clk_div),
        .cpol       (cpol),
        .cpha       (cpha),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .rx_data    (rx_data),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .sdio_o     (sdio_o),
        .sdio_oe    (sdio_oe),
        .sdio_i     (sdio_i)
    );

    always #5 fabric_clk = ~fabric_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pad monitor and slave, both on the falling edge.
    int            busy_cycles, done_cnt, err_cnt, sel_low, other_low, any_low;
    int            edges, oe_viol, gap_cnt, edge_no, mon_sel, mb, midx;
    bit            second_started, mon_cpha;
    logic          prev_sclk = 1'b0;
    logic [NCS-1:0] prev_cs = '1;
    logic [DW-1:0] obs_o, obs_oe, slave_word;

    always @(negedge fabric_clk) begin
        if (busy)  busy_cycles++;
        if (done)  done_cnt++;
        if (error) err_cnt++;
        if (!sdio_oe && sdio_o) oe_viol++;
        if (cs_n != '1) any_low++;
        for (int k = 0; k < NCS; k++) begin
            if (!cs_n[k]) begin
                if (k == mon_sel) sel_low++;
                else              other_low++;
            end
        end
        if (done_cnt >= 1 && !busy && !second_started) gap_cnt++;
        if (done_cnt >= 1 && busy) second_started = 1'b1;
        if (prev_cs != '1 && sclk != prev_sclk) begin
            if (edge_no[0] == mon_cpha) begin
                mb = edge_no >> 1;
                if (mb < DW) begin
                    obs_o[DW-1-mb]  = sdio_o;
                    obs_oe[DW-1-mb] = sdio_oe;
                end
            end
            edge_no++;
            edges++;
        end
        if (cs_n == '1) edge_no = 0;
        prev_sclk = sclk;
        prev_cs   = cs_n;
        // Valid bit only in the half-period before the proper sample edge, inverted otherwise.
        if (edge_no >= int'(mon_cpha)) begin
            midx = (edge_no - int'(mon_cpha)) >> 1;
            sdio_i = (midx < DW) ? (slave_word[DW-1-midx] ^ (edge_no[0] != mon_cpha)) : 1'b0;
        end else begin
            sdio_i = 1'b0;
        end
    end

    task automatic clear_mon(input int sel, input bit cph, input logic [DW-1:0] sw);
        busy_cycles = 0; done_cnt = 0; err_cnt = 0; sel_low = 0; other_low = 0;
        any_low = 0; edges = 0; oe_viol = 0; gap_cnt = 0; second_started = 1'b0;
        obs_o = '0; obs_oe = '0; mon_sel = sel; mon_cpha = cph; slave_word = sw;
    endtask

    task automatic model(input int len, input logic [DW-1:0] data, mask, sw,
                         output logic [DW-1:0] erx, ewr, eoe);
        erx = '0; ewr = '0; eoe = '0;
        for (int i = 0; i < len; i++) begin
            if (mask[DW-1-i]) begin
                ewr[DW-1-i] = data[DW-1-i];
                eoe[DW-1-i] = 1'b1;
            end else begin
                erx[DW-1-i] = sw[DW-1-i];
            end
        end
    endtask

    task automatic drive_req(input int len, input logic [DW-1:0] data, mask,
                             input int sel, input int div, input bit pol, input bit pha);
        tx_len = LW'(len); tx_data = data; tx_rw_mask = mask; cs_sel = 2'(sel);
        clk_div = DVW'(div); cpol = pol; cpha = pha; start = 1'b1;
    endtask

    // Called at posedge+1; inputs are scrambled and start toggled while busy.
    task automatic run_txn(input string tag, input int len, input logic [DW-1:0] data, mask, sw,
                           input int sel, input int div, input bit pol, input bit pha);
        int n;
        logic [DW-1:0] erx, ewr, eoe;
        n = (2 * len + 3) * (div + 1);
        model(len, data, mask, sw, erx, ewr, eoe);
        clear_mon(sel, pha, sw);
        drive_req(len, data, mask, sel, div, pol, pha);
        @(posedge fabric_clk); #1;
        for (int c = 1; c <= n + 3; c++) begin
            if (c < n) begin
                start = 1'($urandom_range(0, 1)); tx_len = LW'($urandom); tx_data = $urandom;
                tx_rw_mask = $urandom; cs_sel = 2'($urandom); clk_div = DVW'($urandom);
                cpol = 1'($urandom); cpha = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge fabric_clk); #1;
        end
        check($sformatf("%s.busy_cycles", tag), busy_cycles, n);
        check($sformatf("%s.done_cnt", tag), done_cnt, 1);
        check($sformatf("%s.err_cnt", tag), err_cnt, 0);
        check($sformatf("%s.rx_data", tag), rx_data, erx);
        check($sformatf("%s.tx_bits", tag), obs_o, ewr);
        check($sformatf("%s.oe_bits", tag), obs_oe, eoe);
        check($sformatf("%s.sclk_edges", tag), edges, 2 * len);
        check($sformatf("%s.cs_low_cycles", tag), sel_low, (2 * len + 2) * (div + 1));
        check($sformatf("%s.other_cs", tag), other_low, 0);
        check($sformatf("%s.sclk_idle", tag), sclk, pol);
        check($sformatf("%s.oe_low_o", tag), oe_viol, 0);
        $display("txn %s len=%0d div=%0d mode=%0d cs=%0d data=%h mask=%h rx=%h exp=%h",
                 tag, len, div, {pol, pha}, sel, data, mask, rx_data, erx);
    endtask

    task automatic run_bad(input string tag, input int len);
        logic [DW-1:0] prev_rx;
        prev_rx = rx_data;
        clear_mon(0, 1'b0, '0);
        drive_req(len, $urandom, $urandom, 1, 0, 1'b0, 1'b0);
        @(posedge fabric_clk); #1;
        start = 1'b0;
        check($sformatf("%s.error_pulse", tag), error, 1);
        check($sformatf("%s.busy_now", tag), busy, 0);
        @(posedge fabric_clk); #1;
        check($sformatf("%s.error_drop", tag), error, 0);
        repeat (3) begin @(posedge fabric_clk); #1; end
        check($sformatf("%s.err_cnt", tag), err_cnt, 1);
        check($sformatf("%s.cs_activity", tag), any_low, 0);
        check($sformatf("%s.busy_cycles", tag), busy_cycles, 0);
        check($sformatf("%s.done_cnt", tag), done_cnt, 0);
        check($sformatf("%s.rx_hold", tag), rx_data, prev_rx);
        check($sformatf("%s.sclk_edges", tag), edges, 0);
        $display("txn %s len=%0d rejected error_cnt=%0d", tag, len, err_cnt);
    endtask

    initial begin
        logic [DW-1:0] sw, d, m, erx, ewr, eoe;
        int n, len;

        reset = 1'b1; start = 1'b0; tx_len = '0; tx_data = '0; tx_rw_mask = '0;
        cs_sel = '0; clk_div = '0; cpol = 1'b0; cpha = 1'b0;
        clear_mon(0, 1'b0, '0);
        repeat (3) begin @(posedge fabric_clk); #1; end
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.error", error, 0);
        check("rst.rx_data", rx_data, 0);
        check("rst.sclk", sclk, 0);
        check("rst.cs_n", cs_n, 4'hF);
        check("rst.sdio_oe", sdio_oe, 0);
        check("rst.sdio_o", sdio_o, 0);
        reset = 1'b0;

        // Started on the very first cycle after reset release.
        run_txn("mode0_a5", 8, 32'hA500_0000, 32'hFF00_0000, $urandom, 0, 1, 1'b0, 1'b0);
        check("mode0_a5.busy38", busy_cycles, 38);

        sw = ($urandom & 32'hFF00_FFFF) | 32'h003C_0000;
        run_txn("mode3_rd", 16, $urandom, 32'hFF00_0000, sw, 2, 2, 1'b1, 1'b1);
        check("mode3_rd.rx3c", rx_data, 32'h003C_0000);

        run_txn("mode1_len1", 1, 32'h0, 32'h0, 32'h8000_0000, 1, 0, 1'b0, 1'b1);
        check("mode1_len1.rx", rx_data, 32'h8000_0000);
        run_txn("mode2_len1", 1, 32'h0, 32'h0, 32'h8000_0000, 0, 0, 1'b1, 1'b0);
        run_txn("mode2_wr", 1, 32'h8000_0000, 32'h8000_0000, $urandom, 2, 0, 1'b1, 1'b0);

        run_bad("len0", 0);
        run_bad("len33", 33);

        run_txn("div_max", 2, 32'h4000_0000, 32'h8000_0000, $urandom, 1, 255, 1'b0, 1'b1);

        // Reset while the 32-bit transfer is on bit 5.
        clear_mon(1, 1'b0, $urandom);
        drive_req(32, $urandom, $urandom, 1, 1, 1'b0, 1'b0);
        @(posedge fabric_clk); #1;
        start = 1'b0;
        for (int c = 0; c < 1000 && edges < 10; c++) begin @(posedge fabric_clk); #1; end
        check("rstmid.reach_bit5", (edges >= 10), 1);
        reset = 1'b1;
        #1;
        check("rstmid.cs_n", cs_n, 4'hF);
        check("rstmid.sclk", sclk, 0);
        check("rstmid.busy", busy, 0);
        check("rstmid.sdio_oe", sdio_oe, 0);
        check("rstmid.done", done, 0);
        repeat (3) begin @(posedge fabric_clk); #1; end
        check("rstmid.no_done", done_cnt, 0);
        $display("txn rstmid aborted after %0d sclk edges", edges);
        reset = 1'b0;
        run_txn("after_rst", 12, $urandom, $urandom, $urandom, 3, 1, 1'b1, 1'b0);

        // Two transfers with start held high on cs 3.
        len = 6; d = $urandom; m = $urandom; sw = $urandom;
        n = (2 * len + 3) * 2;
        model(len, d, m, sw, erx, ewr, eoe);
        clear_mon(3, 1'b1, sw);
        drive_req(len, d, m, 3, 1, 1'b0, 1'b1);
        for (int c = 0; c < 3000 && done_cnt < 1; c++) begin @(posedge fabric_clk); #1; end
        for (int c = 0; c < 10 && !second_started; c++) begin @(posedge fabric_clk); #1; end
        start = 1'b0;
        for (int c = 0; c < 3000 && done_cnt < 2; c++) begin @(posedge fabric_clk); #1; end
        repeat (2) begin @(posedge fabric_clk); #1; end
        check("b2b.done_cnt", done_cnt, 2);
        check("b2b.busy_cycles", busy_cycles, 2 * n);
        check("b2b.idle_gap", gap_cnt, 1);
        check("b2b.other_cs", other_low, 0);
        check("b2b.cs3_low", sel_low, 2 * (2 * len + 2) * 2);
        check("b2b.rx_data", rx_data, erx);
        check("b2b.tx_bits", obs_o, ewr);
        check("b2b.err_cnt", err_cnt, 0);
        $display("txn b2b two transfers cs=3 gap=%0d rx=%h exp=%h", gap_cnt, rx_data, erx);

        for (int t = 0; t < 12; t++) begin
            run_txn($sformatf("rnd%0d", t), $urandom_range(1, DW), $urandom, $urandom, $urandom,
                    $urandom_range(0, NCS - 1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
